raster_bbox_walker: RTL and testbench
=====================================

# raster_bbox_walker

Scan controller between triangle setup and `pixel_processor`. Accepts one triangle's bounding box, origin edge/depth values and per-pixel increments, then walks the box in raster order (left-to-right, top-to-bottom). Emits one candidate pixel per handshake with incrementally updated edge functions and interpolated depth. It is the sole sequencer of the pixel stage: one triangle in flight, never overlapped.

## Interface
- `COORD_BITS`, 12, unsigned integer pixel coordinate width
- `EDGE_BITS`, `FX_TOTAL_BITS*2`, signed edge-function value/step width
- `Z_BITS`, `FX_TOTAL_BITS*2`, depth accumulator width
- `ZSTEP_BITS`, `FX_TOTAL_BITS`, signed depth step width (sign-extended to `Z_BITS` before use)
- `META_BITS`, 32, opaque per-triangle metadata width

- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `vld_in`  in  1  triangle descriptor valid
- `rdy_in`  out  1  walker idle, can accept a descriptor
- `in_min_x`, `in_min_y`, `in_max_x`, `in_max_y`  in  `COORD_BITS` each  inclusive bounding box
- `in_edge_0..2`  in  `EDGE_BITS` each  edge values at (min_x, min_y)
- `in_dedx_0..2`, `in_dedy_0..2`  in  `EDGE_BITS` each  edge step per +1 x / +1 y
- `in_z`  in  `Z_BITS`  depth at (min_x, min_y)
- `in_dzdx`, `in_dzdy`  in  `ZSTEP_BITS`  depth steps
- `in_metadata`  in  `META_BITS`  passed through unchanged
- `flush`  in  1  synchronous abort of current triangle
- `vld_out`  out  1  pixel candidate valid
- `rdy_out`  in  1  downstream (`pixel_processor`) ready
- `pix_x`, `pix_y`  out  `COORD_BITS`  current pixel
- `edge_0..2`  out  `EDGE_BITS`  edge values at current pixel
- `z_out`  out  `Z_BITS`  depth at current pixel
- `metadata_out`  out  `META_BITS`  latched metadata
- `tri_done`  out  1  one-cycle pulse when a triangle finishes or is flushed

## Operation
- States: IDLE, SCAN.
- IDLE:
  - `rdy_in`=1, `vld_out`=0.
  - On `vld_in && rdy_in`, latch all descriptor fields.
  - If `in_max_x < in_min_x` or `in_max_y < in_min_y` (degenerate), stay IDLE and pulse `tri_done` next cycle; no pixel is emitted.
  - Otherwise load cur = origin and row-start = origin, then go to SCAN.
- SCAN:
  - `vld_out`=1; outputs are the current registers. Outputs hold stable while `rdy_out`=0.
  - On handshake (`vld_out && rdy_out`), advance:
    - x < max_x: x+1; edge_i += dedx_i; z += sext(dzdx).
    - x == max_x, y < max_y: x = min_x; y+1; edge_i = row_edge_i + dedy_i; z = row_z + sext(dzdy); row-start registers take the same new values.
    - x == max_x, y == max_y: go to IDLE, pulse `tri_done`.
- Arithmetic: two's-complement add, wrap on overflow, no saturation. Coordinates never exceed max, so no coordinate wrap.
- `flush`:
  - In SCAN, return to IDLE next cycle, drop `vld_out`, pulse `tri_done`. A handshake in the same cycle is honoured (that pixel counts) but no advance occurs.
  - In IDLE, `flush` is ignored and blocks acceptance that cycle (`rdy_in` = IDLE && !flush).
- Reset (any time, including mid-scan): state IDLE; all outputs 0 except `rdy_in`=1; all datapath registers 0.

## Timing
- `rdy_in` is combinational from state and `flush`. All other outputs are registered.
- Accept at edge N → first `vld_out` high after edge N.
- Throughput: 1 pixel/cycle with `rdy_out` held high. A W×H box takes W·H cycles of `vld_out`.
- Last-pixel handshake at edge M → `tri_done`=1 and `rdy_in`=1 in cycle after M. Next descriptor is accepted at edge M+1 at the earliest.
- `tri_done` is never high for more than one cycle. Degenerate accept at N → `tri_done` in cycle after N.

## Test plan
- Box (2,3)-(3,4), edges (10,20,30), dedx (1,2,3), dedy (100,200,300), z=0x1000, dzdx=1, dzdy=0x10, `rdy_out`=1:
  - Pixels (2,3),(3,3),(2,4),(3,4).
  - edge_0 = 10, 11, 110, 111.
  - z = 0x1000, 0x1001, 0x1010, 0x1011.
  - `tri_done` one cycle after the 4th handshake.
- Same box, `rdy_out` toggled 1,0,0,1,…: outputs stable across stalls, exactly 4 handshakes, no duplicate or skipped pixel.
- Degenerate box min_x=5, max_x=4: zero `vld_out` cycles, `tri_done` pulse, `rdy_in` stays 1.
- Single pixel (7,7)-(7,7) with dedx=-1: one pixel, edges unchanged from input. Back-to-back descriptor accepted the cycle after `tri_done`.
- 4×4 box, assert `flush` after 5th handshake: `vld_out` drops next cycle, `tri_done` pulses. A new triangle then starts at its own origin.
- `rst_n` low mid-scan of 4×4 box: `vld_out`=0 and `pix_x`/`pix_y`/`edge_*`/`z_out`=0 immediately (asynchronous). `rdy_in`=1; no `tri_done` pulse.

Source files
------------

// File: rtl/raster_bbox_walker.sv
// Raster-order scan of one triangle's bounding box. Emits one pixel candidate per
// handshake with incrementally stepped edge functions and depth.
module raster_bbox_walker #(
   parameter int COORD_BITS    = 12,
   parameter int FX_TOTAL_BITS = 16,
   parameter int EDGE_BITS     = FX_TOTAL_BITS*2,
   parameter int Z_BITS        = FX_TOTAL_BITS*2,
   parameter int ZSTEP_BITS    = FX_TOTAL_BITS,
   parameter int META_BITS     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vld_in,
   output logic                  rdy_in,
   input  logic [COORD_BITS-1:0] in_min_x,
   input  logic [COORD_BITS-1:0] in_min_y,
   input  logic [COORD_BITS-1:0] in_max_x,
   input  logic [COORD_BITS-1:0] in_max_y,
   input  logic [EDGE_BITS-1:0]  in_edge_0,
   input  logic [EDGE_BITS-1:0]  in_edge_1,
   input  logic [EDGE_BITS-1:0]  in_edge_2,
   input  logic [EDGE_BITS-1:0]  in_dedx_0,
   input  logic [EDGE_BITS-1:0]  in_dedx_1,
   input  logic [EDGE_BITS-1:0]  in_dedx_2,
   input  logic [EDGE_BITS-1:0]  in_dedy_0,
   input  logic [EDGE_BITS-1:0]  in_dedy_1,
   input  logic [EDGE_BITS-1:0]  in_dedy_2,
   input  logic [Z_BITS-1:0]     in_z,
   input  logic [ZSTEP_BITS-1:0] in_dzdx,
   input  logic [ZSTEP_BITS-1:0] in_dzdy,
   input  logic [META_BITS-1:0]  in_metadata,
   input  logic                  flush,
   output logic                  vld_out,
   input  logic                  rdy_out,
   output logic [COORD_BITS-1:0] pix_x,
   output logic [COORD_BITS-1:0] pix_y,
   output logic [EDGE_BITS-1:0]  edge_0,
   output logic [EDGE_BITS-1:0]  edge_1,
   output logic [EDGE_BITS-1:0]  edge_2,
   output logic [Z_BITS-1:0]     z_out,
   output logic [META_BITS-1:0]  metadata_out,
   output logic                  tri_done,
   output logic                  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and held outputs stay stable until then.
   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t state, state_nxt;

   logic [COORD_BITS-1:0] min_x_q, max_x_q, max_y_q;
   logic [EDGE_BITS-1:0]  dedx_q [3];
   logic [EDGE_BITS-1:0]  dedy_q [3];
   logic [EDGE_BITS-1:0]  row_edge_q [3];
   logic [EDGE_BITS-1:0]  cur_edge [3];
   logic [EDGE_BITS-1:0]  in_edge_a [3];
   logic [EDGE_BITS-1:0]  in_dedx_a [3];
   logic [EDGE_BITS-1:0]  in_dedy_a [3];
   logic [Z_BITS-1:0]     dzdx_q, dzdy_q, row_z_q;

   logic accept, degenerate, hs, x_last, y_last;

   assign in_edge_a = '{in_edge_0, in_edge_1, in_edge_2};
   assign in_dedx_a = '{in_dedx_0, in_dedx_1, in_dedx_2};
   assign in_dedy_a = '{in_dedy_0, in_dedy_1, in_dedy_2};

   assign accept     = (state == IDLE) && vld_in && !flush;
   assign degenerate = (in_max_x < in_min_x) || (in_max_y < in_min_y);
   assign hs         = (state == SCAN) && rdy_out;
   assign x_last     = (pix_x == max_x_q);
   assign y_last     = (pix_y == max_y_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && !degenerate) state_nxt = SCAN;
         SCAN: if (flush || (hs && x_last && y_last)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rdy_in    = (state == IDLE) && !flush;
      vld_out   = (state == SCAN);
      dbg_state = (state == SCAN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_x_q      <= '0;
         max_x_q      <= '0;
         max_y_q      <= '0;
         pix_x        <= '0;
         pix_y        <= '0;
         z_out        <= '0;
         row_z_q      <= '0;
         dzdx_q       <= '0;
         dzdy_q       <= '0;
         metadata_out <= '0;
         tri_done     <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            dedx_q[i]     <= '0;
            dedy_q[i]     <= '0;
            row_edge_q[i] <= '0;
            cur_edge[i]   <= '0;
         end
      end else begin
         tri_done <= (accept && degenerate) ||
                     ((state == SCAN) && (flush || (hs && x_last && y_last)));
         if (accept) begin
            min_x_q      <= in_min_x;
            max_x_q      <= in_max_x;
            max_y_q      <= in_max_y;
            pix_x        <= in_min_x;
            pix_y        <= in_min_y;
            z_out        <= in_z;
            row_z_q      <= in_z;
            dzdx_q       <= {{(Z_BITS-ZSTEP_BITS){in_dzdx[ZSTEP_BITS-1]}}, in_dzdx};
            dzdy_q       <= {{(Z_BITS-ZSTEP_BITS){in_dzdy[ZSTEP_BITS-1]}}, in_dzdy};
            metadata_out <= in_metadata;
            for (int i = 0; i < 3; i++) begin
               dedx_q[i]     <= in_dedx_a[i];
               dedy_q[i]     <= in_dedy_a[i];
               row_edge_q[i] <= in_edge_a[i];
               cur_edge[i]   <= in_edge_a[i];
            end
         end else if (hs && !flush) begin
            // A flushed cycle still transfers its pixel but never advances.
            if (!x_last) begin
               pix_x <= pix_x + 1'b1;
               z_out <= z_out + dzdx_q;
               for (int i = 0; i < 3; i++) cur_edge[i] <= cur_edge[i] + dedx_q[i];
            end else if (!y_last) begin
               pix_x   <= min_x_q;
               pix_y   <= pix_y + 1'b1;
               z_out   <= row_z_q + dzdy_q;
               row_z_q <= row_z_q + dzdy_q;
               for (int i = 0; i < 3; i++) begin
                  cur_edge[i]   <= row_edge_q[i] + dedy_q[i];
                  row_edge_q[i] <= row_edge_q[i] + dedy_q[i];
               end
            end
         end
      end
   end

   assign edge_0 = cur_edge[0];
   assign edge_1 = cur_edge[1];
   assign edge_2 = cur_edge[2];

endmodule

// File: tb/tb_raster_bbox_walker.sv
// Bench for raster_bbox_walker: expected pixels are computed directly from the
// descriptor (closed-form, not incremental) and queued at acceptance.
module tb_raster_bbox_walker;

   typedef struct {
      logic [11:0] min_x, min_y, max_x, max_y;
      logic [31:0] e [3];
      logic [31:0] dx [3];
      logic [31:0] dy [3];
      logic [31:0] z;
      logic [15:0] dzdx, dzdy;
      logic [31:0] meta;
   } desc_t;

   // {last, meta, x, y, e0, e1, e2, z}
   localparam int W = 1 + 32 + 12 + 12 + 96 + 32;

   logic        clk = 0, rst_n = 0, vld_in = 0, flush = 0, rdy_out = 0;
   logic [11:0] in_min_x = 0, in_min_y = 0, in_max_x = 0, in_max_y = 0;
   logic [31:0] in_edge_0 = 0, in_edge_1 = 0, in_edge_2 = 0;
   logic [31:0] in_dedx_0 = 0, in_dedx_1 = 0, in_dedx_2 = 0;
   logic [31:0] in_dedy_0 = 0, in_dedy_1 = 0, in_dedy_2 = 0;
   logic [31:0] in_z = 0, in_metadata = 0;
   logic [15:0] in_dzdx = 0, in_dzdy = 0;
   logic        rdy_in, vld_out, tri_done, dbg_state;
   logic [11:0] pix_x, pix_y;
   logic [31:0] edge_0, edge_1, edge_2, z_out, metadata_out;

   logic [W-1:0] exp_q[$];
   int n_checks = 0, n_pass = 0;
   int cyc = 0, hs_count = 0, acc_cyc = -1, done_cyc = -2;
   bit exp_scan = 0, done_due = 0, stall_prev = 0;
   int rdy_mode = 0;
   logic [11:0] sv_x, sv_y;
   logic [31:0] sv_e0, sv_z;

   raster_bbox_walker dut (
      .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
      .in_min_x(in_min_x), .in_min_y(in_min_y), .in_max_x(in_max_x), .in_max_y(in_max_y),
      .in_edge_0(in_edge_0), .in_edge_1(in_edge_1), .in_edge_2(in_edge_2),
      .in_dedx_0(in_dedx_0), .in_dedx_1(in_dedx_1), .in_dedx_2(in_dedx_2),
      .in_dedy_0(in_dedy_0), .in_dedy_1(in_dedy_1), .in_dedy_2(in_dedy_2),
      .in_z(in_z), .in_dzdx(in_dzdx), .in_dzdy(in_dzdy), .in_metadata(in_metadata),
      .flush(flush), .vld_out(vld_out), .rdy_out(rdy_out),
      .pix_x(pix_x), .pix_y(pix_y), .edge_0(edge_0), .edge_1(edge_1), .edge_2(edge_2),
      .z_out(z_out), .metadata_out(metadata_out), .tri_done(tri_done), .dbg_state(dbg_state)
   );

   // clock/reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [31:0] sext(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   // closed-form reference for every pixel of the box
   task automatic push_expected(input desc_t d);
      logic [31:0] e [3];
      logic [31:0] z, dxw, dyw;
      for (int yy = int'(d.min_y); yy <= int'(d.max_y); yy++) begin
         for (int xx = int'(d.min_x); xx <= int'(d.max_x); xx++) begin
            dxw = 32'(xx - int'(d.min_x));
            dyw = 32'(yy - int'(d.min_y));
            for (int i = 0; i < 3; i++) e[i] = d.e[i] + dxw * d.dx[i] + dyw * d.dy[i];
            z = d.z + dxw * sext(d.dzdx) + dyw * sext(d.dzdy);
            exp_q.push_back({(xx == int'(d.max_x) && yy == int'(d.max_y)), d.meta,
                             12'(xx), 12'(yy), e[0], e[1], e[2], z});
         end
      end
   endtask

   task automatic drive_desc(input desc_t d);
      in_min_x = d.min_x; in_min_y = d.min_y; in_max_x = d.max_x; in_max_y = d.max_y;
      in_edge_0 = d.e[0]; in_edge_1 = d.e[1]; in_edge_2 = d.e[2];
      in_dedx_0 = d.dx[0]; in_dedx_1 = d.dx[1]; in_dedx_2 = d.dx[2];
      in_dedy_0 = d.dy[0]; in_dedy_1 = d.dy[1]; in_dedy_2 = d.dy[2];
      in_z = d.z; in_dzdx = d.dzdx; in_dzdy = d.dzdy; in_metadata = d.meta;
   endtask

   task automatic send(input desc_t d);
      bit acc = 0;
      drive_desc(d);
      vld_in = 1;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (rdy_in) begin
            push_expected(d);
            acc = 1;
         end
         @(posedge clk); #1;
      end
      vld_in = 0;
      if (!acc) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk);
         if (!exp_scan && exp_q.size() == 0) ok = 1;
      end
      if (!ok) check("idle_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic desc_t mk_box(input int x0, input int y0, input int x1, input int y1);
      desc_t d;
      d.min_x = 12'(x0); d.min_y = 12'(y0); d.max_x = 12'(x1); d.max_y = 12'(y1);
      for (int i = 0; i < 3; i++) begin
         d.e[i] = $urandom; d.dx[i] = $urandom; d.dy[i] = $urandom;
      end
      d.z = $urandom; d.dzdx = 16'($urandom); d.dzdy = 16'($urandom); d.meta = $urandom;
      return d;
   endfunction

   // rdy_out driver: 0 = always high, 1 = pattern 1,0,0,1, 2 = random
   initial begin
      int k = 0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: rdy_out = 1;
            1: rdy_out = (k % 4 == 0) || (k % 4 == 3);
            default: rdy_out = 1'($urandom_range(0, 1));
         endcase
         k++;
      end
   end

   // scoreboard / cycle model
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            exp_scan = 0; done_due = 0; stall_prev = 0;
         end else begin
            bit acc, deg, hs, last_hs, nd;
            logic [W-1:0] ent;
            cyc++;
            check("vld_out", 32'(vld_out), 32'(exp_scan));
            check("rdy_in", 32'(rdy_in), 32'(!exp_scan && !flush));
            check("tri_done", 32'(tri_done), 32'(done_due));
            if (tri_done) done_cyc = cyc;
            if (stall_prev && vld_out) begin
               check("hold_x", 32'(pix_x), 32'(sv_x));
               check("hold_y", 32'(pix_y), 32'(sv_y));
               check("hold_e0", edge_0, sv_e0);
               check("hold_z", z_out, sv_z);
            end
            stall_prev = vld_out && !rdy_out;
            sv_x = pix_x; sv_y = pix_y; sv_e0 = edge_0; sv_z = z_out;
            acc = vld_in && !exp_scan && !flush;
            if (acc) acc_cyc = cyc;
            deg = (in_max_x < in_min_x) || (in_max_y < in_min_y);
            hs = exp_scan && rdy_out;
            last_hs = 0;
            if (hs) begin
               hs_count++;
               if (exp_q.size() == 0) check("extra_pixel", 1, 0);
               else begin
                  ent = exp_q.pop_front();
                  last_hs = ent[W-1];
                  check("metadata", metadata_out, ent[183:152]);
                  check("pix_x", 32'(pix_x), 32'(ent[151:140]));
                  check("pix_y", 32'(pix_y), 32'(ent[139:128]));
                  check("edge_0", edge_0, ent[127:96]);
                  check("edge_1", edge_1, ent[95:64]);
                  check("edge_2", edge_2, ent[63:32]);
                  check("z_out", z_out, ent[31:0]);
               end
            end
            nd = (acc && deg) || (exp_scan && (flush || (hs && last_hs)));
            if (exp_scan && (flush || (hs && last_hs))) begin
               exp_scan = 0;
               if (flush) exp_q.delete();
            end else if (acc && !deg) exp_scan = 1;
            done_due = nd;
         end
      end
   end

   initial begin
      desc_t d1, d;
      bit ok;
      #1;
      check("rst_rdy_in", 32'(rdy_in), 1);
      check("rst_vld_out", 32'(vld_out), 0);
      check("rst_tri_done", 32'(tri_done), 0);
      check("rst_pix_x", 32'(pix_x), 0);
      check("rst_z", z_out, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      @(posedge clk); #1;

      // basic 2x2 box with known values
      d1.min_x = 2; d1.min_y = 3; d1.max_x = 3; d1.max_y = 4;
      d1.e = '{10, 20, 30}; d1.dx = '{1, 2, 3}; d1.dy = '{100, 200, 300};
      d1.z = 32'h1000; d1.dzdx = 16'h1; d1.dzdy = 16'h10; d1.meta = 32'hCAFE_0001;
      rdy_mode = 0;
      send(d1);
      wait_idle(100);

      // same box with stalls
      rdy_mode = 1;
      d1.meta = 32'hCAFE_0002;
      send(d1);
      wait_idle(100);
      rdy_mode = 0;

      // degenerate box
      send(mk_box(5, 1, 4, 3));
      wait_idle(20);

      // single pixel with negative dedx, then back-to-back
      d = mk_box(7, 7, 7, 7);
      d.dx = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      send(d);
      send(mk_box(1, 1, 2, 1));
      check("b2b_accept", 32'(acc_cyc), 32'(done_cyc));
      wait_idle(50);

      // flush while idle blocks acceptance
      drive_desc(mk_box(0, 0, 1, 1));
      vld_in = 1; flush = 1;
      @(posedge clk); #1;
      vld_in = 0; flush = 0;
      wait_idle(20);

      // flush after the 5th handshake of a 4x4 box, then a fresh triangle
      hs_count = 0;
      send(mk_box(10, 20, 13, 23));
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk); #1;
         if (hs_count >= 5) ok = 1;
      end
      if (!ok) check("flush_wait_timeout", 0, 1);
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      send(mk_box(30, 40, 32, 41));
      wait_idle(50);

      // random boxes with random backpressure
      rdy_mode = 2;
      for (int t = 0; t < 4; t++) begin
         int x0, y0;
         x0 = $urandom_range(0, 100);
         y0 = $urandom_range(0, 100);
         send(mk_box(x0, y0, x0 + $urandom_range(0, 3), y0 + $urandom_range(0, 3)));
         wait_idle(200);
      end
      rdy_mode = 0;

      // asynchronous reset mid-scan
      hs_count = 0;
      send(mk_box(50, 50, 53, 53));
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk); #1;
         if (hs_count >= 3) ok = 1;
      end
      if (!ok) check("reset_wait_timeout", 0, 1);
      #2 rst_n = 0;
      #1;
      check("arst_vld_out", 32'(vld_out), 0);
      check("arst_rdy_in", 32'(rdy_in), 1);
      check("arst_tri_done", 32'(tri_done), 0);
      check("arst_pix_x", 32'(pix_x), 0);
      check("arst_pix_y", 32'(pix_y), 0);
      check("arst_edge_0", edge_0, 0);
      check("arst_edge_1", edge_1, 0);
      check("arst_edge_2", edge_2, 0);
      check("arst_z", z_out, 0);
      check("arst_meta", metadata_out, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      repeat (4) @(posedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
